score_display_scheduler: RTL and testbench
==========================================

SCORE_DISPLAY_SCHEDULER -- requirements
Module: score_display_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1: clocks per digit-scan step, legal range 1..255.
REQ-002 The block SHALL have parameter BLINK_HALF, default 25: clocks per blink half-period in OVER, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port good_evt, input, 1 bit: single-cycle good-collision pulse.
REQ-006 The block SHALL have port bad_evt, input, 1 bit: single-cycle bad-collision pulse.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle restart pulse.
REQ-008 The block SHALL have port max_hit, input, 1 bit: level; the tracker's score is at its maximum.
REQ-009 The block SHALL have port cur_bcd, input, 12 bits: current score as {hundreds, tens, ones}.
REQ-010 The block SHALL have port hi_bcd, input, 12 bits: high score as {hundreds, tens, ones}.
REQ-011 The block SHALL have port score_inc, output, 1 bit: one-cycle increment command to the tracker.
REQ-012 The block SHALL have port score_clr, output, 1 bit: one-cycle clear command to the tracker.
REQ-013 The block SHALL have port digit_sel, output, 2 bits: active digit, 0=ones, 1=tens, 2=hundreds.
REQ-014 The block SHALL have port digit_val, output, 4 bits: BCD value of the active digit.
REQ-015 The block SHALL have port digit_en, output, 1 bit: active digit lit.
REQ-016 The block SHALL have port game_over, output, 1 bit: high while the FSM is in OVER.

Function
REQ-017 The FSM SHALL have exactly two states: PLAY and OVER.
REQ-018 In PLAY, bad_evt=1 SHALL transition to OVER on the next edge.
REQ-019 In PLAY, max_hit=1 SHALL transition to OVER on the next edge.
REQ-020 In OVER, start=1 SHALL transition to PLAY on the next edge; start in PLAY SHALL be ignored.
REQ-021 In PLAY, good_evt=1 with bad_evt=0 and max_hit=0 SHALL produce score_inc=1 in the following cycle only; latency is 1 clock.
REQ-022 When good_evt and bad_evt coincide in PLAY, bad SHALL win: no score_inc, transition to OVER.
REQ-023 In OVER, good_evt and bad_evt SHALL be ignored; score_inc SHALL stay 0.
REQ-024 score_clr SHALL be 1 for exactly the first cycle after an OVER->PLAY transition.
REQ-025 score_inc and score_clr SHALL never be 1 in the same cycle.
REQ-026 digit_sel SHALL advance 0->1->2->0 once every SCAN_DIV clocks, using a prescaler that wraps at SCAN_DIV-1; value 3 SHALL never appear.
REQ-027 digit_val SHALL be the registered nibble of the selected digit, valid in the same cycle as digit_sel.
REQ-028 The digit_val source SHALL be cur_bcd in PLAY and hi_bcd in OVER, sampled one cycle before output.
REQ-029 In PLAY, digit_en SHALL be 1, subject to REQ-036.
REQ-030 In OVER, a blink counter SHALL count 0..BLINK_HALF-1 and toggle blink_phase on each wrap; digit_en SHALL be 0 while blink_phase=1.
REQ-031 On entry to OVER, the blink counter SHALL be set to 0 and blink_phase to 0, so the display starts lit.
REQ-032 game_over SHALL be registered and equal the state (1 in OVER); it SHALL change on the same edge as the state.
REQ-033 The scan prescaler and digit_sel SHALL be free-running and unaffected by state changes.

Reset
REQ-034 While rst=1, the block SHALL hold: state=PLAY, score_inc=0, score_clr=0, digit_sel=0, digit_val=0, digit_en=1, game_over=0, and all counters and blink_phase at 0.
REQ-035 Asserting rst mid-blink or mid-pulse SHALL abort the blink or pulse immediately; the first post-reset edge SHALL behave as PLAY with no pending score_inc.

Configuration
REQ-036 With LEAD_ZERO_BLANK_EN defined: hundreds digit_en SHALL be 0 when its value is 0; tens digit_en SHALL be 0 when hundreds=0 and tens=0; ones SHALL never be blanked; this is ANDed with the blink enable. Without the macro, no blanking SHALL occur.

Verification
REQ-037 Reset, SCAN_DIV=1 -> digit_sel sequence 0,1,2,0,1,2; digit_en=1; game_over=0.
REQ-038 PLAY, good_evt pulse at cycle N -> score_inc=1 at cycle N+1 only; three pulses -> three score_inc pulses.
REQ-039 good_evt+bad_evt at the same cycle -> no score_inc; game_over=1 next cycle; digits show hi_bcd=0x142 as 2,4,1.
REQ-040 OVER, BLINK_HALF=3 -> digit_en pattern 1,1,1,0,0,0 repeating; start pulse -> game_over=0 and a single score_clr pulse.
REQ-041 PLAY, max_hit=1 -> OVER next edge; a good_evt asserted while in OVER is ignored.
REQ-042 With LEAD_ZERO_BLANK_EN, cur_bcd=0x007 -> hundreds and tens digit_en=0, ones digit_en=1 showing 7; without the macro, all three are lit showing 0,0,7.

Source files
------------

// File: rtl/score_display_scheduler.sv
// ----------------------------------------------------------------------------
// score_display_scheduler
//
// Game-flow controller and 3-digit display scanner for a collision game.
// A two-state FSM (PLAY / OVER) turns collision pulses into increment and
// clear commands for an external score tracker. The display side scans the
// three BCD digits one at a time: the current score in PLAY, the blinking
// high score in OVER.
//
// Optional build macro:
//   LEAD_ZERO_BLANK_EN - blank the leading zero digits (hundreds, then tens).
//                        The ones digit is never blanked.
//
// Parameters:
//   SCAN_DIV   - clocks per digit-scan step (1..255)
//   BLINK_HALF - clocks per blink half-period in OVER (1..255)
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   good_evt   in   single-cycle good-collision pulse
//   bad_evt    in   single-cycle bad-collision pulse
//   start      in   single-cycle restart pulse
//   max_hit    in   level, the tracker's score is at its maximum
//   cur_bcd    in   current score {hundreds, tens, ones}
//   hi_bcd     in   high score {hundreds, tens, ones}
//   score_inc  out  one-cycle increment command to the tracker
//   score_clr  out  one-cycle clear command to the tracker
//   digit_sel  out  active digit: 0=ones, 1=tens, 2=hundreds
//   digit_val  out  BCD value of the active digit
//   digit_en   out  active digit lit
//   game_over  out  high while the FSM is in OVER
// ----------------------------------------------------------------------------
module score_display_scheduler #(
    parameter int unsigned SCAN_DIV   = 1,
    parameter int unsigned BLINK_HALF = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        good_evt,
    input  logic        bad_evt,
    input  logic        start,
    input  logic        max_hit,
    input  logic [11:0] cur_bcd,
    input  logic [11:0] hi_bcd,
    output logic        score_inc,
    output logic        score_clr,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_val,
    output logic        digit_en,
    output logic        game_over
);

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    state_t state, state_next;
    logic   inc_next, clr_next;

    // ------------------------------------------------------------------
    // FSM next-state and command decode
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        inc_next   = 1'b0;
        clr_next   = 1'b0;
        case (state)
            PLAY: begin
                // A bad collision or a saturated score ends the game and
                // takes priority over a coincident good collision.
                if (bad_evt || max_hit) begin
                    state_next = OVER;
                end else if (good_evt) begin
                    inc_next = 1'b1;
                end
            end
            OVER: begin
                if (start) begin
                    state_next = PLAY;
                    clr_next   = 1'b1;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    // inc is only decoded in PLAY and clr only in OVER, so the two commands
    // are mutually exclusive by construction.
    // NOTE: the reset is asynchronous, so it appears in the sensitivity list
    // and aborts any pending pulse the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PLAY;
            game_over <= 1'b0;
            score_inc <= 1'b0;
            score_clr <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state     <= state_next;
            game_over <= (state_next == OVER);
            score_inc <= inc_next;
            score_clr <= clr_next;
        end
    end

    // ------------------------------------------------------------------
    // Free-running digit scan
    // ------------------------------------------------------------------
    logic [7:0]  scan_cnt;
    logic        scan_wrap;
    logic [1:0]  sel_next;
    logic [11:0] src_bcd;
    logic [3:0]  nib_next;

    assign scan_wrap = (scan_cnt == 8'(SCAN_DIV - 1));
    assign src_bcd   = (state == OVER) ? hi_bcd : cur_bcd;

    always_comb begin
        sel_next = digit_sel;
        if (scan_wrap) begin
            sel_next = (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
        end
    end

    // The value register is loaded with the nibble for the digit that
    // becomes active on this edge, so digit_val lines up with digit_sel.
    always_comb begin
        nib_next = src_bcd[3:0];
        case (sel_next)
            2'd1:    nib_next = src_bcd[7:4];
            2'd2:    nib_next = src_bcd[11:8];
            default: nib_next = src_bcd[3:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= 8'd0;
            digit_sel <= 2'd0;
            digit_val <= 4'd0;
        end else begin
            scan_cnt  <= scan_wrap ? 8'd0 : scan_cnt + 8'd1;
            digit_sel <= sel_next;
            digit_val <= nib_next;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator (OVER only)
    // ------------------------------------------------------------------
    logic [7:0] blink_cnt;
    logic       blink_phase;

    // Counting only while staying in OVER clears the blinker on entry and
    // on exit, so the display always starts lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (state == OVER && state_next == OVER) begin
            if (blink_cnt == 8'(BLINK_HALF - 1)) begin
                blink_cnt   <= 8'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end else begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Digit enable
    // ------------------------------------------------------------------
`ifdef LEAD_ZERO_BLANK_EN
    // Zero flags are sampled from the same source and edge as digit_val so
    // the blanking decision always matches the digit on display.
    logic hund_zero, tens_zero;
    logic lead_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hund_zero <= 1'b0;
            tens_zero <= 1'b0;
        end else begin
            hund_zero <= (src_bcd[11:8] == 4'd0);
            tens_zero <= (src_bcd[7:4] == 4'd0);
        end
    end

    always_comb begin
        lead_ok = 1'b1;
        case (digit_sel)
            2'd2:    lead_ok = ~hund_zero;
            2'd1:    lead_ok = ~(hund_zero & tens_zero);
            default: lead_ok = 1'b1;
        endcase
    end

    assign digit_en = ~blink_phase & lead_ok;
`else
    assign digit_en = ~blink_phase;
`endif

endmodule

// File: tb/tb_score_display_scheduler.sv
// ----------------------------------------------------------------------------
// tb_score_display_scheduler
//
// Self-checking bench for score_display_scheduler with SCAN_DIV=1 and
// BLINK_HALF=3. Increment commands are tracked with a scoreboard queue of
// expected cycle numbers; digit scan is tracked with a bench-side counter.
// ----------------------------------------------------------------------------
module tb_score_display_scheduler;

    localparam int unsigned SCAN_DIV   = 1;
    localparam int unsigned BLINK_HALF = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        good_evt, bad_evt, start, max_hit;
    logic [11:0] cur_bcd, hi_bcd;
    logic        score_inc, score_clr;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_val;
    logic        digit_en, game_over;

    score_display_scheduler #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .good_evt  (good_evt),
        .bad_evt   (bad_evt),
        .start     (start),
        .max_hit   (max_hit),
        .cur_bcd   (cur_bcd),
        .hi_bcd    (hi_bcd),
        .score_inc (score_inc),
        .score_clr (score_clr),
        .digit_sel (digit_sel),
        .digit_val (digit_val),
        .digit_en  (digit_en),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_sel  = 0;
    int inc_q[$];

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) exp_sel = 0;
        else     exp_sel = (exp_sel + 1) % 3;
    endtask

    function automatic logic [3:0] nib(input logic [11:0] b, input int s);
        case (s)
            0:       return b[3:0];
            1:       return b[7:4];
            default: return b[11:8];
        endcase
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; good_evt = 1'b1; bad_evt = 1'b0; start = 1'b0;
        max_hit = 1'b0; cur_bcd = 12'h000; hi_bcd = 12'h000;
        tick();
        tick();
        checks++; if (score_inc !== 1'b0) begin failures++; $display("FAIL rst_inc got=%b exp=0", score_inc); end
        checks++; if (score_clr !== 1'b0) begin failures++; $display("FAIL rst_clr got=%b exp=0", score_clr); end
        checks++; if (digit_sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", digit_sel); end
        checks++; if (digit_val !== 4'd0) begin failures++; $display("FAIL rst_val got=%0d exp=0", digit_val); end
        checks++; if (digit_en !== 1'b1) begin failures++; $display("FAIL rst_en got=%b exp=1", digit_en); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL rst_over got=%b exp=0", game_over); end
        good_evt = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (digit_sel !== 2'(exp_sel)) begin failures++; $display("FAIL scan_sel got=%0d exp=%0d", digit_sel, exp_sel); end
            checks++; if (digit_en !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL scan_en_over got=%b%b exp=10", digit_en, game_over); end
            checks++; if (score_inc !== 1'b0) begin failures++; $display("FAIL post_rst_inc got=%b exp=0", score_inc); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_good_inc();
        int pat[10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        int e;
        cur_bcd = 12'h123;
        for (int i = 0; i < 10; i++) begin
            good_evt = pat[i][0];
            if (pat[i] != 0) inc_q.push_back(cyc + 1);
            tick();
            good_evt = 1'b0;
            checks++;
            if (score_inc === 1'b1) begin
                if (inc_q.size() == 0) begin
                    failures++; $display("FAIL inc_unexpected got=1 exp=0 cyc=%0d", cyc);
                end else begin
                    e = inc_q.pop_front();
                    if (e != cyc) begin failures++; $display("FAIL inc_cycle got=%0d exp=%0d", cyc, e); end
                end
            end else if (inc_q.size() > 0 && inc_q[0] <= cyc) begin
                e = inc_q.pop_front();
                failures++; $display("FAIL inc_missing got=%b exp=1 cyc=%0d", score_inc, e);
            end
            checks++; if (score_clr !== 1'b0) begin failures++; $display("FAIL play_clr got=%b exp=0", score_clr); end
            checks++; if (digit_val !== nib(cur_bcd, exp_sel)) begin failures++; $display("FAIL play_val got=%0d exp=%0d", digit_val, nib(cur_bcd, exp_sel)); end
        end
        checks++; if (inc_q.size() != 0) begin failures++; $display("FAIL inc_leftover got=%0d exp=0", inc_q.size()); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_good_bad_coincide();
        cur_bcd = 12'h999; hi_bcd = 12'h142;
        good_evt = 1'b1; bad_evt = 1'b1;
        tick();
        good_evt = 1'b0; bad_evt = 1'b0;
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL gb_over got=%b exp=1", game_over); end
        checks++; if (score_inc !== 1'b0) begin failures++; $display("FAIL gb_inc got=%b exp=0", score_inc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (digit_val !== nib(hi_bcd, exp_sel)) begin failures++; $display("FAIL hi_val sel=%0d got=%0d exp=%0d", exp_sel, digit_val, nib(hi_bcd, exp_sel)); end
            checks++; if (score_inc !== 1'b0 || game_over !== 1'b1) begin failures++; $display("FAIL gb_hold got=%b%b exp=01", score_inc, game_over); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_blink_restart();
        logic exp_en;
        int   clr_seen;
        // Leave OVER, then re-enter for a clean blink sequence.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (game_over !== 1'b0 || score_clr !== 1'b1) begin failures++; $display("FAIL restart1 got=over%b clr%b exp=over0 clr1", game_over, score_clr); end
        tick();
        checks++; if (score_clr !== 1'b0) begin failures++; $display("FAIL restart1_clr2 got=%b exp=0", score_clr); end
        bad_evt = 1'b1;
        tick();
        bad_evt = 1'b0;
        checks++; if (game_over !== 1'b1 || digit_en !== 1'b1) begin failures++; $display("FAIL blink_entry got=over%b en%b exp=over1 en1", game_over, digit_en); end
        for (int k = 1; k < 12; k++) begin
            good_evt = (k % 4 == 1);
            tick();
            good_evt = 1'b0;
            exp_en = ((k / int'(BLINK_HALF)) % 2 == 0);
            checks++; if (digit_en !== exp_en) begin failures++; $display("FAIL blink_en k=%0d got=%b exp=%b", k, digit_en, exp_en); end
            checks++; if (score_inc !== 1'b0) begin failures++; $display("FAIL over_inc k=%0d got=%b exp=0", k, score_inc); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (game_over !== 1'b0 || digit_en !== 1'b1) begin failures++; $display("FAIL restart2 got=over%b en%b exp=over0 en1", game_over, digit_en); end
        clr_seen = (score_clr === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (score_clr === 1'b1) clr_seen++;
        end
        checks++; if (clr_seen != 1) begin failures++; $display("FAIL clr_count got=%0d exp=1", clr_seen); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_max_hit();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (game_over !== 1'b0 || score_clr !== 1'b0) begin failures++; $display("FAIL play_start got=over%b clr%b exp=over0 clr0", game_over, score_clr); end
        max_hit = 1'b1; good_evt = 1'b1;
        tick();
        max_hit = 1'b0; good_evt = 1'b0;
        checks++; if (game_over !== 1'b1 || score_inc !== 1'b0) begin failures++; $display("FAIL max_over got=over%b inc%b exp=over1 inc0", game_over, score_inc); end
        tick();
        checks++; if (score_inc !== 1'b0) begin failures++; $display("FAIL max_inc got=%b exp=0", score_inc); end
        good_evt = 1'b1;
        tick();
        good_evt = 1'b0;
        tick();
        checks++; if (score_inc !== 1'b0 || game_over !== 1'b1) begin failures++; $display("FAIL over_good got=inc%b over%b exp=inc0 over1", score_inc, game_over); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (game_over !== 1'b0 || score_clr !== 1'b1) begin failures++; $display("FAIL max_restart got=over%b clr%b exp=over0 clr1", game_over, score_clr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_lead_zero();
        logic exp_en;
        cur_bcd = 12'h007;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef LEAD_ZERO_BLANK_EN
            exp_en = (exp_sel == 0);
`else
            exp_en = 1'b1;
`endif
            checks++; if (digit_val !== nib(cur_bcd, exp_sel)) begin failures++; $display("FAIL lz_val sel=%0d got=%0d exp=%0d", exp_sel, digit_val, nib(cur_bcd, exp_sel)); end
            checks++; if (digit_en !== exp_en) begin failures++; $display("FAIL lz_en sel=%0d got=%b exp=%b", exp_sel, digit_en, exp_en); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_abort();
        cur_bcd = 12'h456;
        // Abort a pending increment pulse.
        good_evt = 1'b1;
        tick();
        good_evt = 1'b0;
        checks++; if (score_inc !== 1'b1) begin failures++; $display("FAIL abort_pre_inc got=%b exp=1", score_inc); end
        #2 rst = 1'b1;
        exp_sel = 0;
        #1;
        checks++; if (score_inc !== 1'b0 || digit_sel !== 2'd0) begin failures++; $display("FAIL abort_inc got=inc%b sel%0d exp=inc0 sel0", score_inc, digit_sel); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (score_inc !== 1'b0 || game_over !== 1'b0) begin failures++; $display("FAIL abort_post got=inc%b over%b exp=inc0 over0", score_inc, game_over); end
        // Abort a blink in its dark phase.
        bad_evt = 1'b1;
        tick();
        bad_evt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (digit_en !== 1'b0) begin failures++; $display("FAIL abort_dark got=%b exp=0", digit_en); end
        #2 rst = 1'b1;
        exp_sel = 0;
        #1;
        checks++; if (digit_en !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL abort_blink got=en%b over%b exp=en1 over0", digit_en, game_over); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (game_over !== 1'b0 || digit_en !== 1'b1 || score_inc !== 1'b0) begin failures++; $display("FAIL abort_blink_post got=over%b en%b inc%b exp=over0 en1 inc0", game_over, digit_en, score_inc); end
        checks++; if (digit_sel !== 2'(exp_sel)) begin failures++; $display("FAIL abort_sel got=%0d exp=%0d", digit_sel, exp_sel); end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_good_inc();
        test_good_bad_coincide();
        test_blink_restart();
        test_max_hit();
        test_lead_zero();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
